// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned
// instructions with their PCs, and presents the head entry to decode.
module fetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ready,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       stall_D,
    output logic [31:0]                Instr,
    output logic [31:0]                pc,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      fetch_pc;
    logic             inflight;
    logic [31:0]      inflight_pc;

    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             enq;
    logic             deq;

    // Handshake: a request transfers on a cycle where imem_req && imem_ready;
    // its data is on imem_rdata exactly one cycle later. Decode consumes the
    // head on a cycle where instr_valid && !stall_D.
    always_comb begin
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        imem_req    = reset && !redirect && (credit_used < (CNT_W + 1)'(DEPTH));
        imem_addr   = fetch_pc;
        accept      = imem_req && imem_ready;
        instr_valid = reset && (count != '0);
        occupancy   = reset ? count : '0;
        Instr       = instr_valid ? instr_mem[rd_ptr] : NOP_INSTR;
        pc          = instr_valid ? pc_mem[rd_ptr] : 32'h0;
        enq         = inflight;
        deq         = instr_valid && !stall_D;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            // The response landing this cycle belongs to the old stream.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (!enq && deq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (reset && !redirect && enq) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
